// File: rtl/e_mdu_pkg.sv
// Shared constants and types for the E-stage multiply/divide unit.
package e_mdu_pkg;

  // MD operation code driven by E-stage control.
  typedef enum logic [3:0] {
    OP_MULT  = 4'd0,
    OP_MULTU = 4'd1,
    OP_DIV   = 4'd2,
    OP_DIVU  = 4'd3,
    OP_MFHI  = 4'd4,
    OP_MFLO  = 4'd5,
    OP_MTHI  = 4'd6,
    OP_MTLO  = 4'd7,
    OP_MADD  = 4'd8,
    OP_MADDU = 4'd9,
    OP_MSUB  = 4'd10,
    OP_MSUBU = 4'd11,
    OP_NONE  = 4'd15
  } md_op_e;

  // SPECIAL funct codes for the MD instructions.
  localparam logic [5:0] FUNCT_MFHI  = 6'h10;
  localparam logic [5:0] FUNCT_MTHI  = 6'h11;
  localparam logic [5:0] FUNCT_MFLO  = 6'h12;
  localparam logic [5:0] FUNCT_MTLO  = 6'h13;
  localparam logic [5:0] FUNCT_MULT  = 6'h18;
  localparam logic [5:0] FUNCT_MULTU = 6'h19;
  localparam logic [5:0] FUNCT_DIV   = 6'h1a;
  localparam logic [5:0] FUNCT_DIVU  = 6'h1b;

  // SPECIAL2 opcode and funct codes for the multiply-accumulate forms.
  localparam logic [5:0] OPCODE_SPECIAL2 = 6'h1c;
  localparam logic [5:0] FUNCT_MADD      = 6'h00;
  localparam logic [5:0] FUNCT_MADDU     = 6'h01;
  localparam logic [5:0] FUNCT_MSUB      = 6'h04;
  localparam logic [5:0] FUNCT_MSUBU     = 6'h05;

  // Multi-cycle ops are the ones that occupy the busy countdown.
  function automatic logic is_multi(input md_op_e op);
    return (op inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU,
                       OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU});
  endfunction

  function automatic logic is_div(input md_op_e op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/e_mdu_if.sv
// Request/result bundle between E-stage control and the MD unit.
interface e_mdu_if #(
  parameter int WIDTH = 32
);
  logic             Start;
  logic [3:0]       Op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Busy;
  logic [WIDTH-1:0] HI;
  logic [WIDTH-1:0] LO;

  modport master (output Start, Op, A, B, input  Busy, HI, LO);
  modport slave  (input  Start, Op, A, B, output Busy, HI, LO);
endinterface

// File: rtl/e_mdu_arith.sv
// Combinational datapath: computes the {HI,LO} value an MD op will commit.
module e_mdu_arith
  import e_mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  md_op_e             i_op,
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  input  logic [WIDTH-1:0]   i_hi,
  input  logic [WIDTH-1:0]   i_lo,
  output logic [2*WIDTH-1:0] o_result,
  output logic               o_div0
);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [2*WIDTH-1:0] w_acc;
  logic [2*WIDTH-1:0] w_sprod;
  logic [2*WIDTH-1:0] w_uprod;
  logic [WIDTH-1:0]   w_divisor;
  logic [WIDTH-1:0]   w_squo;
  logic [WIDTH-1:0]   w_srem;
  logic [WIDTH-1:0]   w_uquo;
  logic [WIDTH-1:0]   w_urem;
  logic               w_b_zero;
  logic               w_sovf;

  assign w_acc = {i_hi, i_lo};
  // Sign-extended operands give the signed product modulo 2^(2*WIDTH).
  assign w_sprod = {{WIDTH{i_a[WIDTH-1]}}, i_a} * {{WIDTH{i_b[WIDTH-1]}}, i_b};
  assign w_uprod = {{WIDTH{1'b0}}, i_a} * {{WIDTH{1'b0}}, i_b};

  // Divisor is forced to 1 on div-by-zero so the dividers never see zero.
  assign w_b_zero  = (i_b == '0);
  assign w_divisor = w_b_zero ? ONE : i_b;
  assign w_sovf    = (i_a == MOST_NEG) && (i_b == '1);
  assign w_squo    = $signed(i_a) / $signed(w_divisor);
  assign w_srem    = $signed(i_a) % $signed(w_divisor);
  assign w_uquo    = i_a / w_divisor;
  assign w_urem    = i_a % w_divisor;

  // Select the pending result; non-arith ops and div-by-zero keep {HI,LO}.
  always_comb begin
    o_result = w_acc;
    o_div0   = 1'b0;
    case (i_op)
      OP_MULT:  o_result = w_sprod;
      OP_MULTU: o_result = w_uprod;
      OP_MADD:  o_result = w_acc + w_sprod;
      OP_MADDU: o_result = w_acc + w_uprod;
      OP_MSUB:  o_result = w_acc - w_sprod;
      OP_MSUBU: o_result = w_acc - w_uprod;
      OP_DIV: begin
        if (w_b_zero)    o_div0   = 1'b1;
        else if (w_sovf) o_result = {{WIDTH{1'b0}}, MOST_NEG};
        else             o_result = {w_srem, w_squo};
      end
      OP_DIVU: begin
        if (w_b_zero) o_div0   = 1'b1;
        else          o_result = {w_urem, w_uquo};
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/e_mdu.sv
// E-stage multiply/divide unit: HI/LO registers plus busy countdown.
module e_mdu
  import e_mdu_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic    clk,
  input  logic    reset,
  e_mdu_if.slave  bus
);
  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);
  localparam logic [CW-1:0] MULT_N = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DIV_N  = CW'(DIV_CYCLES);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic {S_IDLE, S_RUN} state_e;

  state_e             r_state;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_pending;
  logic               r_div0;
  logic               r_busy;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  md_op_e             w_op;
  logic [2*WIDTH-1:0] w_result;
  logic               w_div0;

  assign w_op = md_op_e'(bus.Op);

  e_mdu_arith #(.WIDTH(WIDTH)) u_arith (
    .i_op     (w_op),
    .i_a      (bus.A),
    .i_b      (bus.B),
    .i_hi     (r_hi),
    .i_lo     (r_lo),
    .o_result (w_result),
    .o_div0   (w_div0)
  );

  // Control FSM: accept an op in IDLE, count down in RUN, commit on the last edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_pending <= '0;
      r_div0    <= 1'b0;
      r_busy    <= 1'b0;
      r_hi      <= '0;
      r_lo      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.Start && is_multi(w_op)) begin
            r_pending <= w_result;
            r_div0    <= w_div0;
            r_cnt     <= is_div(w_op) ? DIV_N : MULT_N;
            r_busy    <= 1'b1;
            r_state   <= S_RUN;
          end
          // Moves to HI/LO only land while idle; in RUN they are dropped.
          if (w_op == OP_MTHI) r_hi <= bus.A;
          if (w_op == OP_MTLO) r_lo <= bus.A;
        end
        S_RUN: begin
          r_cnt <= r_cnt - CNT_ONE;
          if (r_cnt == CNT_ONE) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
            if (!r_div0) {r_hi, r_lo} <= r_pending;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.Busy = r_busy;
  assign bus.HI   = r_hi;
  assign bus.LO   = r_lo;
endmodule

// File: tb/tb_e_mdu.sv
// Directed bench for e_mdu: scoreboard of expected {HI,LO} and busy lengths.
module tb_e_mdu;
  localparam int W  = 32;
  localparam int MC = 5;
  localparam int DC = 10;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    int           cycles;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb[$];

  e_mdu_if #(.WIDTH(W)) bus ();

  e_mdu #(.WIDTH(W), .MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Independent 64-bit model of the multiply-accumulate forms.
  function automatic logic [2*W-1:0] mac_model(input logic [W-1:0] hi, lo, a, b,
                                               input bit sgn, input bit sub);
    logic [63:0] acc;
    logic [63:0] p;
    acc = {hi, lo};
    if (sgn) p = longint'($signed(a)) * longint'($signed(b));
    else     p = {32'b0, a} * {32'b0, b};
    return sub ? acc - p : acc + p;
  endfunction

  // Called at a negedge with the unit idle; returns just after the sampling edge.
  task automatic start_op(input logic [3:0] op, input logic [W-1:0] a, b,
                          input logic [W-1:0] ehi, elo, input int ecyc);
    exp_t e;
    e.hi = ehi; e.lo = elo; e.cycles = ecyc;
    sb.push_back(e);
    bus.Start = 1'b1; bus.Op = op; bus.A = a; bus.B = b;
    @(posedge clk); #1;
    bus.Start = 1'b0; bus.Op = 4'hF;
  endtask

  // Counts remaining busy cycles, then compares against the oldest expectation.
  task automatic wait_done(input string tag);
    int   cyc;
    exp_t e;
    cyc = 0;
    @(negedge clk);
    while (bus.Busy === 1'b1 && cyc < 200) begin
      cyc++;
      @(negedge clk);
    end
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'(cyc), 32'hFFFF_FFFF);
    end else begin
      e = sb.pop_front();
      check({tag, "_cycles"}, 32'(cyc), 32'(e.cycles));
      check({tag, "_hi"}, bus.HI, e.hi);
      check({tag, "_lo"}, bus.LO, e.lo);
    end
    $display("op %s done: busy=%0d HI=%h LO=%h", tag, cyc, bus.HI, bus.LO);
  endtask

  // Called at a negedge; writes HI or LO and checks it one edge later.
  task automatic mt(input bit to_hi, input logic [W-1:0] v);
    bus.Op = to_hi ? 4'd6 : 4'd7; bus.A = v;
    @(posedge clk); #1;
    bus.Op = 4'hF;
    @(negedge clk);
    if (to_hi) check("mthi", bus.HI, v);
    else       check("mtlo", bus.LO, v);
    $display("mt%s %h", to_hi ? "hi" : "lo", v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2*W-1:0] m;
    logic [W-1:0]   ra, rb, rh, rl;
    logic [3:0]     rop;

    reset = 1'b1;
    bus.Start = 1'b0; bus.Op = 4'hF; bus.A = '0; bus.B = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'b0, bus.Busy}, 32'd0);
    check("rst_hi", bus.HI, 32'd0);
    check("rst_lo", bus.LO, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // 1: signed and unsigned multiply
    start_op(4'd0, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, MC);
    check("mult_busy_e0", {31'b0, bus.Busy}, 32'd1);
    wait_done("mult");
    start_op(4'd1, 32'hFFFF_FFFE, 32'd3, 32'h0000_0002, 32'hFFFF_FFFA, MC);
    wait_done("multu");

    // 2: signed divide, then divide by zero leaves HI/LO alone
    start_op(4'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, DC);
    wait_done("div");
    start_op(4'd3, 32'd7, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFD, DC);
    wait_done("divu_by0");
    start_op(4'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, DC);
    wait_done("div_ovf");

    // 3: accumulate with carry out of LO, subtract with borrow
    mt(1'b1, 32'h1);
    mt(1'b0, 32'hFFFF_FFFF);
    start_op(4'd9, 32'd1, 32'd1, 32'h2, 32'h0, MC);
    wait_done("maddu");
    mt(1'b1, 32'h0);
    mt(1'b0, 32'h0);
    start_op(4'd10, 32'd1, 32'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MC);
    wait_done("msub");

    // Random accumulate cases against the model
    for (int i = 0; i < 4; i++) begin
      ra = $urandom; rb = $urandom; rh = $urandom; rl = $urandom;
      rop = 4'(8 + i);
      mt(1'b1, rh);
      mt(1'b0, rl);
      m = mac_model(rh, rl, ra, rb, (i % 2) == 0, i >= 2);
      start_op(rop, ra, rb, m[63:32], m[31:0], MC);
      wait_done($sformatf("mac_op%0d", rop));
    end

    // 4: Start mult and mthi while a div is in flight are both ignored
    start_op(4'd3, 32'd100, 32'd7, 32'd2, 32'd14, DC - 4);
    repeat (3) @(negedge clk);
    bus.Start = 1'b1; bus.Op = 4'd0; bus.A = 32'd9; bus.B = 32'd9;
    @(posedge clk); #1;
    bus.Start = 1'b0; bus.Op = 4'd6; bus.A = 32'h55;
    @(posedge clk); #1;
    bus.Op = 4'hF;
    wait_done("div_ignore");

    // 5: reset mid-operation aborts without commit
    bus.Start = 1'b1; bus.Op = 4'd0; bus.A = 32'd3; bus.B = 32'd4;
    @(posedge clk); #1;
    bus.Start = 1'b0; bus.Op = 4'hF;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("abort_busy", {31'b0, bus.Busy}, 32'd0);
    check("abort_hi", bus.HI, 32'd0);
    check("abort_lo", bus.LO, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (8) @(negedge clk);
    check("post_abort_busy", {31'b0, bus.Busy}, 32'd0);
    check("post_abort_hi", bus.HI, 32'd0);
    check("post_abort_lo", bus.LO, 32'd0);
    $display("reset abort: Busy=%b HI=%h LO=%h", bus.Busy, bus.HI, bus.LO);

    // 6: back-to-back, next Start in the cycle Busy falls
    start_op(4'd0, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, MC);
    wait_done("b2b_mult");
    start_op(4'd3, 32'd7, 32'd2, 32'd1, 32'd3, DC);
    check("b2b_busy_e0", {31'b0, bus.Busy}, 32'd1);
    wait_done("b2b_divu");

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
